// File: rtl/ones_collector_pkg.sv
// Shared types and helpers for the one-hot collector and its serializer counterpart.
package ones_collector_pkg;

    localparam int unsigned NO_VC_DEFAULT = 13;
    localparam int unsigned ONEHOT_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // True when exactly one bit of vec is set (vectors up to ONEHOT_MAX_W bits).
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ones_collector_onehot_check.sv
// Combinational popcount==1 detector, parameterized on the VC count.
module ones_collector_onehot_check
    import ones_collector_pkg::*;
#(
    parameter int unsigned no_vc = NO_VC_DEFAULT
) (
    input  logic [no_vc-1:0] vec,
    output logic             onehot_c
);

    always_comb begin
        onehot_c = is_onehot(ONEHOT_MAX_W'(vec));
    end

endmodule

// File: rtl/ones_collector.sv
// Reassembles a stream of one-hot VC grants into the multi-hot vector they came from.
// Optional COLLECT timeout is compiled in with ONES_COLLECTOR_TIMEOUT_EN.
module ones_collector
    import ones_collector_pkg::*;
#(
    parameter int unsigned no_vc = NO_VC_DEFAULT,
    parameter int unsigned TO_W  = 8
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             start,
    input  logic [no_vc-1:0] exp_mask,
    input  logic             in_vld,
    input  logic [no_vc-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [no_vc-1:0] out,
    output logic             err
);

    state_e             state_q, state_d;
    logic [no_vc-1:0]   exp_q,   exp_d;
    logic [no_vc-1:0]   acc_q,   acc_d;
    logic [no_vc-1:0]   out_q,   out_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    logic               in_onehot_c;
    logic               item_ok_c;
    logic [no_vc-1:0]   acc_merge_c;

`ifdef ONES_COLLECTOR_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

    ones_collector_onehot_check #(
        .no_vc (no_vc)
    ) u_onehot_check (
        .vec      (in),
        .onehot_c (in_onehot_c)
    );

    // An item is legal only if it is one-hot, expected, and not yet collected.
    always_comb begin
        item_ok_c   = in_onehot_c
                    && ((in & ~exp_q) == '0)
                    && ((in & acc_q) == '0);
        acc_merge_c = acc_q | in;
    end

    // Next-state and output logic; busy/done/out lag the state by one edge.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        err_d   = err_q;
        out_d   = out_q;
        busy_d  = (state_q == COLLECT);
        done_d  = (state_q == DONE);
`ifdef ONES_COLLECTOR_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif

        if (state_q == DONE) begin
            out_d = acc_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    exp_d   = exp_mask;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = (exp_mask == '0) ? DONE : COLLECT;
`ifdef ONES_COLLECTOR_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            COLLECT: begin
                // start wins over any item in the same cycle
                if (start) begin
                    exp_d   = exp_mask;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = (exp_mask == '0) ? DONE : COLLECT;
`ifdef ONES_COLLECTOR_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (in_vld && item_ok_c) begin
                    acc_d = acc_merge_c;
                    if (acc_merge_c == exp_q) begin
                        state_d = DONE;
                    end
`ifdef ONES_COLLECTOR_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    if (in_vld) begin
                        err_d = 1'b1;
                    end
`ifdef ONES_COLLECTOR_TIMEOUT_EN
                    // Saturating at all-ones gives up on the batch with the partial vector.
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == '1) begin
                        err_d    = 1'b1;
                        state_d  = DONE;
                        to_cnt_d = '0;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= IDLE;
            exp_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ONES_COLLECTOR_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef ONES_COLLECTOR_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ones_collector.sv
// Self-checking bench for ones_collector: directed scenarios, then randomized traffic against a set-level model.
module tb_ones_collector;

    localparam int unsigned NV   = 13;
    localparam int unsigned TOW  = 4;
    localparam int          TO_LIMIT = (1 << TOW) - 1;

    logic          clk = 1'b0;
    logic          rs;
    logic          start;
    logic [NV-1:0] exp_mask;
    logic          in_vld;
    logic [NV-1:0] d_in;
    logic          busy;
    logic          done;
    logic [NV-1:0] out;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the batch as a set of expected and collected VCs.
    logic [NV-1:0] m_exp, m_acc;
    logic          m_err, m_collecting, m_completed;
    int            m_idle;
    logic          e_busy, e_done;
    logic [NV-1:0] e_out;

    always #5 clk = ~clk;

    ones_collector #(
        .no_vc (NV),
        .TO_W  (TOW)
    ) dut (
        .clk      (clk),
        .rs       (rs),
        .start    (start),
        .exp_mask (exp_mask),
        .in_vld   (in_vld),
        .in       (d_in),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Apply the batch rules to the inputs seen at this edge.
    task automatic model_edge();
        logic hit;
        if (rs) begin
            m_exp = '0; m_acc = '0; m_err = 1'b0;
            m_collecting = 1'b0; m_completed = 1'b0; m_idle = 0;
            e_busy = 1'b0; e_done = 1'b0; e_out = '0;
            return;
        end
        e_busy = m_collecting;
        e_done = m_completed;
        if (m_completed) e_out = m_acc;
        m_completed = 1'b0;
        if (start) begin
            m_exp = exp_mask; m_acc = '0; m_err = 1'b0; m_idle = 0;
            m_collecting = (exp_mask != '0);
            m_completed  = (exp_mask == '0);
        end else if (m_collecting) begin
            hit = in_vld && ($countones(d_in) == 1) && ((d_in & ~m_exp) == '0) && ((d_in & m_acc) == '0);
            if (in_vld && !hit) m_err = 1'b1;
            if (hit) begin
                m_acc  = m_acc | d_in;
                m_idle = 0;
                if (m_acc == m_exp) begin
                    m_collecting = 1'b0;
                    m_completed  = 1'b1;
                end
            end else begin
`ifdef ONES_COLLECTOR_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO_LIMIT) begin
                    m_err = 1'b1; m_collecting = 1'b0; m_completed = 1'b1; m_idle = 0;
                end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("out",  32'(out),  32'(e_out));
        chk("err",  32'(err),  32'(m_err));
    endtask

    task automatic drive(input logic r, input logic s, input logic [NV-1:0] m,
                         input logic v, input logic [NV-1:0] i);
        rs = r; start = s; exp_mask = m; in_vld = v; d_in = i;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic item(input logic [NV-1:0] i);
        drive(1'b0, 1'b0, '0, 1'b1, i);
    endtask

    task automatic begin_batch(input logic [NV-1:0] m);
        drive(1'b0, 1'b1, m, 1'b0, '0);
    endtask

    function automatic logic [NV-1:0] pick_missing(input logic [NV-1:0] e, input logic [NV-1:0] a);
        logic [NV-1:0] miss;
        int            base;
        miss = e & ~a;
        base = int'($urandom_range(0, NV - 1));
        for (int k = 0; k < int'(NV); k++) begin
            if (miss[(base + k) % NV]) return NV'(1) << ((base + k) % NV);
        end
        return NV'(1) << base;
    endfunction

    initial begin
        rs = 1'b1; start = 1'b0; exp_mask = '0; in_vld = 1'b0; d_in = '0;
        m_exp = '0; m_acc = '0; m_err = 1'b0; m_collecting = 1'b0; m_completed = 1'b0;
        m_idle = 0; e_busy = 1'b0; e_done = 1'b0; e_out = '0;

        // Reset state
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Normal batch
        begin_batch(13'h0015);
        item(13'h0001);
        item(13'h0004);
        item(13'h0010);
        chk("normal_busy_before_done", 32'(busy), 32'h1);
        idle();
        chk("normal_done", 32'(done), 32'h1);
        chk("normal_out", 32'(out), 32'h0015);
        chk("normal_busy_falls", 32'(busy), 32'h0);
        idle();
        chk("normal_done_one_cycle", 32'(done), 32'h0);

        // Empty mask
        begin_batch(13'h0000);
        chk("empty_busy", 32'(busy), 32'h0);
        idle();
        chk("empty_done", 32'(done), 32'h1);
        chk("empty_out", 32'(out), 32'h0);
        chk("empty_busy_after", 32'(busy), 32'h0);
        idle();

        // Duplicate item
        begin_batch(13'h0003);
        item(13'h0001);
        item(13'h0001);
        chk("dup_err", 32'(err), 32'h1);
        item(13'h0002);
        idle();
        chk("dup_done", 32'(done), 32'h1);
        chk("dup_out", 32'(out), 32'h0003);
        idle();
        chk("dup_err_sticky", 32'(err), 32'h1);

        // Illegal items: not one-hot, then outside the mask
        begin_batch(13'h0006);
        chk("start_clears_err", 32'(err), 32'h0);
        item(13'h0006);
        chk("illegal_err", 32'(err), 32'h1);
        item(13'h0008);
        item(13'h0002);
        item(13'h0004);
        idle();
        chk("illegal_done", 32'(done), 32'h1);
        chk("illegal_out", 32'(out), 32'h0006);
        idle();

        // Restart mid-batch; start wins over a simultaneous item
        begin_batch(13'h1F00);
        item(13'h0100);
        item(13'h0200);
        drive(1'b0, 1'b1, 13'h0001, 1'b1, 13'h0400);
        item(13'h0001);
        chk("abort_no_early_done", 32'(done), 32'h0);
        idle();
        chk("abort_done", 32'(done), 32'h1);
        chk("abort_out", 32'(out), 32'h0001);
        idle();

        // Reset mid-batch
        begin_batch(13'h0003);
        item(13'h0001);
        drive(1'b1, 1'b0, '0, 1'b1, 13'h0002);
        chk("rs_busy", 32'(busy), 32'h0);
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_out", 32'(out), 32'h0);
        idle();
        chk("rs_no_done", 32'(done), 32'h0);

`ifdef ONES_COLLECTOR_TIMEOUT_EN
        // Timeout after TO_LIMIT idle COLLECT cycles
        begin_batch(13'h0003);
        item(13'h0001);
        for (int k = 0; k < TO_LIMIT; k++) idle();
        chk("to_not_yet", 32'(done), 32'h0);
        idle();
        chk("to_done", 32'(done), 32'h1);
        chk("to_out", 32'(out), 32'h0001);
        chk("to_err", 32'(err), 32'h1);
        idle();
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int            r;
            logic          r_rs, r_start, r_vld;
            logic [NV-1:0] r_mask, r_item;
            r       = int'($urandom_range(0, 199));
            r_rs    = (r == 0);
            r_start = (r >= 1) && (r <= 12);
            r_mask  = ($urandom_range(0, 7) == 0) ? '0 : NV'($urandom & $urandom & $urandom);
            r_vld   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       r_item = NV'($urandom);
                1:       r_item = NV'(1) << $urandom_range(0, NV - 1);
                default: r_item = pick_missing(m_exp, m_acc);
            endcase
            drive(r_rs, r_start, r_mask, r_vld, r_item);
        end

        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ones_collector.md
Name: ones_collector

Overview:
- Receive-side counterpart of the one-hot serializer: accepts a stream of one-hot items, one per cycle, and reassembles them into the multi-hot vector they came from.
- A batch opens with `start` and an expected mask. It completes when every expected bit has arrived exactly once, then emits the assembled vector with a one-cycle `done` pulse.
- Sits at the VC-grant consumer end of the router pipeline.

Parameters:
- no_vc, 13, width of the item/mask vectors (number of VCs)
- TO_W, 8, timeout counter width; used only when the optional feature is compiled in

Ports:
- clk  input  1  clock, rising edge
- rs  input  1  reset, synchronous, active-high
- start  input  1  open a new batch; `exp_mask` sampled this cycle
- exp_mask  input  no_vc  set of bits the batch must collect
- in_vld  input  1  `in` carries an item this cycle
- in  input  no_vc  item; must be one-hot
- busy  output  1  high while in COLLECT
- done  output  1  one-cycle pulse; batch complete
- out  output  no_vc  assembled vector; registered, updated only on done, held otherwise
- err  output  1  sticky protocol error; cleared by start or rs

Behaviour:
- All outputs registered. Internal registers: `exp`, `acc`.
- rs=1 at a clock edge:
  - state=IDLE; acc=0, exp=0.
  - out=0, done=0, busy=0, err=0.
  - Overrides all other inputs; a batch aborted by rs produces no done.
- IDLE:
  - start=1: exp<=exp_mask, acc<=0, err<=0.
  - If exp_mask==0, go to DONE; otherwise go to COLLECT.
  - in_vld is ignored in IDLE.
- COLLECT (busy=1): an item with in_vld=1 is accepted only if all three hold:
  - popcount(in)==1;
  - (in & ~exp)==0;
  - (in & acc)==0.
  - Any violation: err<=1, item discarded, state unchanged.
  - Accepted item: acc<=acc|in. If (acc|in)==exp, go to DONE.
- DONE:
  - done=1 for exactly one cycle, out=acc, busy=0.
  - Next state is IDLE unless start=1 this cycle, in which case the new batch loads as in IDLE.
  - The done pulse is never suppressed.
- Latency:
  - Last accepted item at edge N gives done=1 in the cycle after edge N+1 (registered output).
  - Empty-mask batch: done follows start by the same two-edge latency.
- Simultaneous events:
  - start and in_vld both high in COLLECT: start wins, item discarded, no done for the aborted batch, err cleared.
  - start while busy restarts cleanly with the new mask.
- Throughput: one item per cycle, no backpressure (`in_vld` is never stalled).
- Width rule: all vector logic is exactly no_vc bits; no_vc>=2.

Optional Feature:
- Macro: ONES_COLLECTOR_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on start and on each accepted item, and increments every COLLECT cycle without an accepted item.
  - On reaching 2^TO_W-1: err<=1, go to DONE, out=partial acc.
  - Counter cleared by rs.
- Undefined: no counter; COLLECT waits indefinitely for missing bits.

Decomposition:
- Shared package:
  - state enum (IDLE, COLLECT, DONE);
  - default no_vc constant shared with the serializer;
  - function `is_onehot(vec)`.
- One sub-module is natural: `onehot_check`, a combinational popcount==1 detector, no_vc-parameterized and reusable by the serializer's checker.
- Everything else stays in the top-level.

Test Plan (no_vc=13):
- Normal batch: start, exp_mask=13'h0015; items 13'h0001, 13'h0004, 13'h0010 on consecutive cycles -> done one cycle after the third item is accepted, out=13'h0015, err=0, busy falls with done.
- Empty mask: start, exp_mask=0 -> done pulses one cycle after the state edge, out=0, err=0, busy never asserted.
- Duplicate: exp_mask=13'h0003; items 13'h0001, 13'h0001, 13'h0002 -> err=1 after the second item, done with out=13'h0003, err stays 1 until next start.
- Illegal items: exp_mask=13'h0006; items 13'h0006 (not one-hot), then 13'h0008 (outside mask) -> err=1, acc unchanged; then 13'h0002, 13'h0004 -> done, out=13'h0006.
- Abort/reset:
  - exp_mask=13'h1F00, two items, then start with exp_mask=13'h0001 plus item 13'h0001 the next cycle -> single done, out=13'h0001, no done for the first batch.
  - Separately, rs mid-batch -> busy=0, done=0, out=0 the next cycle.
- With ONES_COLLECTOR_TIMEOUT_EN, TO_W=4: exp_mask=13'h0003, item 13'h0001, then idle -> done after 15 idle COLLECT cycles, out=13'h0001, err=1.
